// File: rtl/aes_ctr_stream_rx.sv
// Receive-side AES-CTR front end: builds {nonce,ctr} counter blocks, prefetches one
// keystream block from the AES core, and XORs it with each accepted ciphertext block.
module aes_ctr_stream_rx #(
    parameter int CTR_W       = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk_g,
    input  logic                 rst_n,
    input  logic                 cfg_load_i,
    input  logic [127-CTR_W:0]   cfg_nonce_i,
    input  logic [CTR_W-1:0]     cfg_ctr_i,
    input  logic                 ct_valid_i,
    output logic                 ct_ready_o,
    input  logic [127:0]         ct_data_i,
    input  logic                 ct_last_i,
    output logic                 pt_valid_o,
    input  logic                 pt_ready_i,
    output logic [127:0]         pt_data_o,
    output logic                 pt_last_o,
    output logic                 core_req_o,
    output logic [127:0]         core_ctr_o,
    input  logic                 core_done_i,
    input  logic [127:0]         core_ks_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic [2:0]           dbg_state_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_UNCFG   = 3'd0,
        ST_START   = 3'd1,
        ST_GEN     = 3'd2,
        ST_HAVE_KS = 3'd3,
        ST_OUT     = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    state_t               state_q;
    logic [127-CTR_W:0]   nonce_q;
    logic [CTR_W-1:0]     ctr_q;
    logic [127:0]         ks_q;
    logic                 wrap_q;
    logic [TMO_W-1:0]     tmo_q;

    // Both streams transfer on a rising clk_g edge where valid & ready are high; a
    // source holds valid and payload stable until that edge, ready never waits on valid.
    assign ct_ready_o  = (state_q == ST_HAVE_KS);
    assign core_req_o  = (state_q == ST_GEN);
    assign busy_o      = (state_q == ST_START) || (state_q == ST_GEN) ||
                         (state_q == ST_HAVE_KS) || (state_q == ST_OUT);
    assign err_o       = (state_q == ST_ERR);
    assign core_ctr_o  = {nonce_q, ctr_q};
    assign dbg_state_o = state_q;

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNCFG;
            nonce_q    <= '0;
            ctr_q      <= '0;
            ks_q       <= '0;
            wrap_q     <= 1'b0;
            tmo_q      <= '0;
            err_code_o <= 2'b00;
            pt_valid_o <= 1'b0;
            pt_data_o  <= '0;
            pt_last_o  <= 1'b0;
        end else if (cfg_load_i) begin
            // A reload aborts everything, including a core result still in flight.
            nonce_q    <= cfg_nonce_i;
            ctr_q      <= cfg_ctr_i;
            wrap_q     <= 1'b0;
            tmo_q      <= '0;
            err_code_o <= 2'b00;
            pt_valid_o <= 1'b0;
            state_q    <= ST_START;
        end else begin
            case (state_q)
                ST_START: state_q <= ST_GEN;
                ST_GEN: begin
                    if (core_done_i) begin
                        ks_q    <= core_ks_i;
                        ctr_q   <= ctr_q + CTR_W'(1);
                        wrap_q  <= wrap_q | (&ctr_q);
                        tmo_q   <= '0;
                        state_q <= ST_HAVE_KS;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        tmo_q      <= '0;
                        err_code_o <= 2'b01;
                        state_q    <= ST_ERR;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_HAVE_KS: begin
                    if (ct_valid_i) begin
                        pt_data_o  <= ct_data_i ^ ks_q;
                        pt_last_o  <= ct_last_i;
                        pt_valid_o <= 1'b1;
                        state_q    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (pt_ready_i) begin
                        pt_valid_o <= 1'b0;
                        if (pt_last_o) begin
                            state_q <= ST_UNCFG;
                        end else if (wrap_q) begin
                            // The next counter value would repeat keystream.
                            err_code_o <= 2'b10;
                            state_q    <= ST_ERR;
                        end else begin
                            state_q <= ST_GEN;
                        end
                    end
                end
                ST_ERR:   state_q <= ST_ERR;
                default:  state_q <= ST_UNCFG;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_stream_rx.sv
// Randomized bench for aes_ctr_stream_rx: a behavioural AES-core stand-in, a plaintext
// sink and a scoreboard predicting ct ^ ks({nonce, ctr+i}) for every block.
module tb_aes_ctr_stream_rx;

    localparam int CTR_W       = 32;
    localparam int TIMEOUT_CYC = 256;
    localparam logic [127:0] CT0 = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic         clk_g;
    logic         rst_n;
    logic         cfg_load_i;
    logic [95:0]  cfg_nonce_i;
    logic [31:0]  cfg_ctr_i;
    logic         ct_valid_i;
    logic         ct_ready_o;
    logic [127:0] ct_data_i;
    logic         ct_last_i;
    logic         pt_valid_o;
    logic         pt_ready_i;
    logic [127:0] pt_data_o;
    logic         pt_last_o;
    logic         core_req_o;
    logic [127:0] core_ctr_o;
    logic         core_done_i;
    logic [127:0] core_ks_i;
    logic         busy_o;
    logic         err_o;
    logic [1:0]   err_code_o;
    logic [2:0]   dbg_state_o;

    aes_ctr_stream_rx #(.CTR_W(CTR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_g       (clk_g),
        .rst_n       (rst_n),
        .cfg_load_i  (cfg_load_i),
        .cfg_nonce_i (cfg_nonce_i),
        .cfg_ctr_i   (cfg_ctr_i),
        .ct_valid_i  (ct_valid_i),
        .ct_ready_o  (ct_ready_o),
        .ct_data_i   (ct_data_i),
        .ct_last_i   (ct_last_i),
        .pt_valid_o  (pt_valid_o),
        .pt_ready_i  (pt_ready_i),
        .pt_data_o   (pt_data_o),
        .pt_last_o   (pt_last_o),
        .core_req_o  (core_req_o),
        .core_ctr_o  (core_ctr_o),
        .core_done_i (core_done_i),
        .core_ks_i   (core_ks_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_g = 1'b0;
    always #5 clk_g = ~clk_g;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];
    logic         exp_last_q[$];
    logic [127:0] exp_ctr_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Keystream of the stand-in core: any fixed function of the counter block will do.
    logic ks_ones;
    function automatic logic [127:0] ks_fn(input logic [127:0] blk);
        logic [127:0] r;
        r = {blk[63:0] ^ 64'h9E37_79B9_7F4A_7C15, blk[127:64] + 64'hC2B2_AE3D_27D4_EB4F};
        return ks_ones ? {128{1'b1}} : r;
    endfunction

    // ---------------- AES core stand-in ----------------
    logic         core_en;
    int           lat_min, lat_max;
    logic         resp_done, man_done;
    logic [127:0] resp_ks, man_ks;
    assign core_done_i = resp_done | man_done;
    assign core_ks_i   = man_done ? man_ks : resp_ks;

    initial begin
        int age;
        int lat;
        logic [127:0] held_ctr;
        age = 0; lat = 0; held_ctr = '0;
        resp_done = 1'b0; resp_ks = '0;
        forever begin
            @(posedge clk_g); #1;
            resp_done = 1'b0;
            if (!core_req_o) begin
                age = 0;
            end else begin
                if (age == 0) begin
                    check("ctr_avail", 128'(exp_ctr_q.size() != 0), 128'(1));
                    if (exp_ctr_q.size() != 0) held_ctr = exp_ctr_q.pop_front();
                    check("core_ctr", core_ctr_o, held_ctr);
                    lat = $urandom_range(lat_min, lat_max);
                end else begin
                    check("ctr_stable", core_ctr_o, held_ctr);
                end
                if (core_en && age == lat) begin
                    resp_done = 1'b1;
                    resp_ks   = ks_fn(core_ctr_o);
                end
                age++;
            end
        end
    end

    // ---------------- plaintext sink ----------------
    logic sink_block, rand_ready;
    int   pt_cnt = 0;
    int   stall_at, stall_len;

    initial begin
        int stall_done;
        stall_done = 0;
        pt_ready_i = 1'b0;
        forever begin
            @(posedge clk_g); #1;
            if (!pt_valid_o) stall_done = 0;
            if (sink_block) begin
                pt_ready_i = 1'b0;
            end else if (pt_valid_o && pt_cnt == stall_at && stall_done < stall_len) begin
                pt_ready_i = 1'b0;
                stall_done++;
            end else begin
                pt_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        logic         prev_stall;
        logic [127:0] held_data;
        logic         held_last;
        prev_stall = 1'b0; held_data = '0; held_last = 1'b0;
        forever begin
            @(negedge clk_g);
            if (pt_valid_o) begin
                check("ct_ready_in_out", 128'(ct_ready_o), 128'(0));
                if (prev_stall) begin
                    check("pt_hold_data", pt_data_o, held_data);
                    check("pt_hold_last", 128'(pt_last_o), 128'(held_last));
                end
                if (pt_ready_i) begin
                    check("pt_avail", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) begin
                        check("pt_data", pt_data_o, exp_q.pop_front());
                        check("pt_last", 128'(pt_last_o), 128'(exp_last_q.pop_front()));
                    end
                    pt_cnt++;
                end
            end
            prev_stall = pt_valid_o && !pt_ready_i;
            held_data  = pt_data_o;
            held_last  = pt_last_o;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_cfg(input logic [95:0] n, input logic [31:0] c);
        @(posedge clk_g); #1;
        cfg_load_i = 1'b1; cfg_nonce_i = n; cfg_ctr_i = c;
        @(posedge clk_g); #1;
        cfg_load_i = 1'b0;
    endtask

    task automatic send_ct(input logic [127:0] d, input logic l);
        int budget;
        repeat ($urandom_range(0, 2)) @(posedge clk_g);
        #1;
        ct_valid_i = 1'b1; ct_data_i = d; ct_last_i = l;
        budget = 0;
        forever begin
            @(negedge clk_g);
            if (ct_ready_o || budget > 1000) break;
            budget++;
        end
        check("ct_accept", 128'(budget <= 1000), 128'(1));
        @(posedge clk_g); #1;
        ct_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 3000) begin
            @(negedge clk_g);
            k++;
        end
        check(tag, 128'(k < 3000), 128'(1));
    endtask

    // Predicts every counter block and plaintext of a message, then plays it in.
    task automatic run_msg(input logic [95:0] n, input logic [31:0] c, input int len);
        logic [127:0] ct[];
        ct = new[len];
        for (int i = 0; i < len; i++) begin
            logic [31:0] ci;
            ci = c + 32'(i);
            ct[i] = rnd128();
            exp_ctr_q.push_back({n, ci});
            exp_q.push_back(ct[i] ^ ks_fn({n, ci}));
            exp_last_q.push_back(i == len - 1);
        end
        do_cfg(n, c);
        for (int i = 0; i < len; i++) send_ct(ct[i], i == len - 1);
        wait_idle("msg_done");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [95:0]  n, nb;
        logic [31:0]  c, cb;
        logic [127:0] d;
        int           k, t_r, t_e, req_seen;

        rst_n = 1'b1; cfg_load_i = 1'b0; cfg_nonce_i = '0; cfg_ctr_i = '0;
        ct_valid_i = 1'b0; ct_data_i = '0; ct_last_i = 1'b0;
        core_en = 1'b1; lat_min = 0; lat_max = 3; ks_ones = 1'b0;
        man_done = 1'b0; man_ks = '0;
        sink_block = 1'b0; rand_ready = 1'b0; stall_at = -1; stall_len = 0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_ct_ready", 128'(ct_ready_o), 128'(0));
        check("rst_pt_valid", 128'(pt_valid_o), 128'(0));
        check("rst_pt_data", pt_data_o, 128'(0));
        check("rst_core_req", 128'(core_req_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        check("rst_err_code", 128'(err_code_o), 128'(0));
        repeat (2) @(posedge clk_g);
        #3 rst_n = 1'b1;
        ct_valid_i = 1'b1;
        repeat (3) @(posedge clk_g);
        #1;
        check("uncfg_ct_ready", 128'(ct_ready_o), 128'(0));
        check("uncfg_core_req", 128'(core_req_o), 128'(0));
        check("uncfg_busy", 128'(busy_o), 128'(0));
        ct_valid_i = 1'b0;

        // Single block, all-ones keystream after 15 cycles: plaintext is ~ct
        ks_ones = 1'b1; lat_min = 15; lat_max = 15;
        exp_ctr_q.push_back(128'h1);
        exp_q.push_back(~CT0);
        exp_last_q.push_back(1'b1);
        do_cfg(96'h0, 32'h1);
        send_ct(CT0, 1'b1);
        wait_idle("single_done");
        check("single_busy", 128'(busy_o), 128'(0));
        check("single_ct_ready", 128'(ct_ready_o), 128'(0));
        ks_ones = 1'b0;

        // Three blocks, 5-cycle sink stall on block 2
        lat_min = 1; lat_max = 4;
        stall_at = pt_cnt + 1; stall_len = 5;
        run_msg({$urandom, $urandom, $urandom}, 32'h1, 3);
        stall_at = -1;

        // Randomized messages with random core latency and sink back-pressure
        rand_ready = 1'b1; lat_min = 0; lat_max = 5;
        for (int m = 0; m < 6; m++) begin
            run_msg({$urandom, $urandom, $urandom}, 32'($urandom_range(0, 32'hFFFF_FF00)),
                    $urandom_range(1, 4));
        end
        rand_ready = 1'b0;

        // Counter wrap: block using ctr all-ones is fine, then error 10 with no new request
        n = {$urandom, $urandom, $urandom};
        d = rnd128();
        exp_ctr_q.push_back({n, 32'hFFFF_FFFF});
        exp_q.push_back(d ^ ks_fn({n, 32'hFFFF_FFFF}));
        exp_last_q.push_back(1'b0);
        do_cfg(n, 32'hFFFF_FFFF);
        send_ct(d, 1'b0);
        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin @(negedge clk_g); k++; end
        check("wrap_pt_seen", 128'(k < 1000), 128'(1));
        @(posedge clk_g); #1;
        check("wrap_err", 128'(err_o), 128'(1));
        check("wrap_code", 128'(err_code_o), 128'(2'b10));
        check("wrap_busy", 128'(busy_o), 128'(0));
        req_seen = 0;
        ct_valid_i = 1'b1;
        repeat (20) begin
            @(posedge clk_g); #1;
            if (core_req_o || ct_ready_o) req_seen++;
        end
        ct_valid_i = 1'b0;
        check("wrap_quiet", 128'(req_seen), 128'(0));

        // Timeout: core never answers
        core_en = 1'b0;
        n = {$urandom, $urandom, $urandom}; c = $urandom;
        exp_ctr_q.push_back({n, c});
        do_cfg(n, c);
        check("cfg_err_clr", 128'(err_o), 128'(0));
        check("cfg_code_clr", 128'(err_code_o), 128'(0));
        t_r = -1; t_e = -1;
        for (int i = 0; i < 600 && t_e < 0; i++) begin
            @(posedge clk_g); #1;
            if (core_req_o && t_r < 0) t_r = i;
            if (err_o && t_e < 0) t_e = i;
        end
        check("tmo_seen", 128'(t_e >= 0 && t_r >= 0), 128'(1));
        check("tmo_cycles", 128'(t_e - t_r), 128'(TIMEOUT_CYC));
        check("tmo_code", 128'(err_code_o), 128'(2'b01));
        check("tmo_core_req", 128'(core_req_o), 128'(0));
        check("tmo_ct_ready", 128'(ct_ready_o), 128'(0));

        // Reload mid-GEN: one-cycle request gap, late done in START ignored
        n = {$urandom, $urandom, $urandom}; c = $urandom;
        exp_ctr_q.push_back({n, c});
        do_cfg(n, c);
        repeat (4) @(posedge clk_g);
        #1;
        check("midgen_req", 128'(core_req_o), 128'(1));
        nb = {$urandom, $urandom, $urandom}; cb = 32'($urandom_range(0, 32'hFFFF_0000));
        exp_ctr_q.push_back({nb, cb});
        do_cfg(nb, cb);
        man_done = 1'b1; man_ks = rnd128();
        core_en = 1'b1; lat_min = 2; lat_max = 2;
        check("start_gap", 128'(core_req_o), 128'(0));
        check("start_busy", 128'(busy_o), 128'(1));
        @(posedge clk_g); #1;
        man_done = 1'b0;
        check("restart_req", 128'(core_req_o), 128'(1));
        check("restart_ctr", core_ctr_o, {nb, cb});
        d = rnd128();
        exp_q.push_back(d ^ ks_fn({nb, cb}));
        exp_last_q.push_back(1'b1);
        send_ct(d, 1'b1);
        wait_idle("restart_done");

        // Asynchronous reset while a plaintext block is waiting in OUT
        sink_block = 1'b1; lat_min = 0; lat_max = 3;
        n = {$urandom, $urandom, $urandom}; c = $urandom_range(0, 1000);
        d = rnd128();
        exp_ctr_q.push_back({n, c});
        exp_q.push_back(d ^ ks_fn({n, c}));
        exp_last_q.push_back(1'b1);
        do_cfg(n, c);
        send_ct(d, 1'b1);
        k = 0;
        while (!pt_valid_o && k < 100) begin @(negedge clk_g); k++; end
        check("out_reached", 128'(pt_valid_o), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_pt_valid", 128'(pt_valid_o), 128'(0));
        check("arst_core_req", 128'(core_req_o), 128'(0));
        check("arst_busy", 128'(busy_o), 128'(0));
        exp_q.delete();
        exp_last_q.delete();
        sink_block = 1'b0;
        repeat (2) @(negedge clk_g);
        rst_n = 1'b1;
        ct_valid_i = 1'b1; ct_data_i = rnd128();
        repeat (3) @(posedge clk_g);
        #1;
        check("post_rst_ct_ready", 128'(ct_ready_o), 128'(0));
        check("post_rst_busy", 128'(busy_o), 128'(0));
        ct_valid_i = 1'b0;

        // Recovery after reset
        rand_ready = 1'b1;
        run_msg({$urandom, $urandom, $urandom}, 32'($urandom_range(0, 32'hFFFF_FF00)), 3);

        // ---------------- final report ----------------
        repeat (5) @(posedge clk_g);
        check("exp_q_empty", 128'(exp_q.size()), 128'(0));
        check("exp_ctr_q_empty", 128'(exp_ctr_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_ctr_stream_rx.md
Name: aes_ctr_stream_rx

Overview:
- Receive-side CTR-mode front end: accepts ciphertext blocks on a valid/ready stream and returns plaintext blocks on a second valid/ready stream.
- Builds counter blocks {nonce, ctr} and drives the AES keystream core through a req/done handshake.
- Prefetches one keystream block ahead of the ciphertext, then XORs it with each accepted ciphertext block.
- Sits between the bus-side DMA/FIFO and the AES core; the core's key is loaded elsewhere.

Parameters:
- CTR_W, 32, width of the incrementing counter field (low bits of the counter block); nonce width = 128-CTR_W.
- TIMEOUT_CYC, 256, max cycles core_req_o may stay high without core_done_i before error.

Ports:
- clk_g  in  1  clock
- rst_n  in  1  reset
- cfg_load_i  in  1  pulse: load nonce/counter, abort any message in flight
- cfg_nonce_i  in  128-CTR_W  nonce, sampled on cfg_load_i
- cfg_ctr_i  in  CTR_W  initial counter, sampled on cfg_load_i
- ct_valid_i  in  1  ciphertext valid
- ct_ready_o  out  1  ciphertext ready
- ct_data_i  in  128  ciphertext block
- ct_last_i  in  1  last block of message
- pt_valid_o  out  1  plaintext valid
- pt_ready_i  in  1  plaintext ready
- pt_data_o  out  128  plaintext block
- pt_last_o  out  1  last flag, forwarded from ct_last_i
- core_req_o  out  1  keystream request, held until done
- core_ctr_o  out  128  counter block {nonce,ctr}, stable while core_req_o=1
- core_done_i  in  1  keystream valid (single-cycle)
- core_ks_i  in  128  keystream block
- busy_o  out  1  message in progress
- err_o  out  1  sticky error
- err_code_o  out  2  01 timeout, 10 counter wrap

Behaviour:
- Reset is rst_n, asynchronous, active-low, on clock clk_g.
- All outputs reset to 0; all internal registers clear; state UNCFG.
- States: UNCFG, START, GEN, HAVE_KS, OUT, ERR.
- cfg_load_i has priority over every other event in every state.
  - Loads nonce and ctr, clears err_o, err_code_o, pt_valid_o, the wrap flag and the timeout counter.
  - Next state is START; any in-flight core result is discarded.
- UNCFG: ct_ready_o=0, core_req_o=0, busy_o=0; waits for cfg_load_i.
- START: one cycle with core_req_o=0 (guaranteed request gap), then GEN.
- GEN:
  - core_req_o=1; core_ctr_o={nonce,ctr}; timeout counter increments each cycle.
  - On core_done_i: ks_reg<=core_ks_i; ctr<=ctr+1 (mod 2^CTR_W); wrap flag set if ctr was all-ones; timeout counter clears; next HAVE_KS. core_req_o drops the next cycle.
  - Timeout counter reaching TIMEOUT_CYC without done: ERR with code 01.
- core_done_i outside GEN is ignored.
- HAVE_KS: ct_ready_o=1. On ct_valid_i & ct_ready_o, registered 1-cycle latency:
  - pt_data_o<=ct_data_i^ks_reg; pt_last_o<=ct_last_i; pt_valid_o<=1; next OUT.
- OUT: ct_ready_o=0; pt_data_o/pt_last_o held stable while pt_valid_o=1 & ~pt_ready_i. On pt_ready_i, pt_valid_o<=0 and:
  - if pt_last_o=1: UNCFG (each message needs a new cfg_load);
  - else if wrap flag set: ERR, code 10 (no keystream reuse);
  - else: GEN (the request gap is satisfied by OUT).
- ERR: err_o=1; ct_ready_o=0, pt_valid_o=0, core_req_o=0; leave only via cfg_load_i or reset.
- busy_o=1 in START, GEN, HAVE_KS and OUT.
- Steady-state throughput: one block per (core latency + 3) cycles.
- ct_ready_o is combinational from state only; it never depends on ct_valid_i.
- Reset mid-GEN drops core_req_o asynchronously; the core is expected to abort on req deassert.

Test Plan:
- Single block: cfg_load nonce=0, ctr=1; core returns ks=0xFF..FF after 15 cycles; ct=0x0123..CDEF, last=1 -> core_ctr_o=0x...0001; pt=~ct with last=1; state returns to UNCFG, busy_o=0.
- Three-block message with pt_ready_i low for 5 cycles on block 2:
  - core_ctr_o = ...01, ...02, ...03;
  - pt_data_o stable during the stall;
  - no ct_ready_o during OUT.
- Counter wrap: cfg_ctr=0xFFFFFFFF, two-block message -> block 1 uses ctr 0xFFFFFFFF and its output is correct; after its pt handshake err_o=1, err_code_o=10, no second core_req_o.
- Timeout: core_done_i held 0 -> err_o=1, code 01, exactly TIMEOUT_CYC cycles after core_req_o rises; core_req_o=0 in ERR.
- cfg_load_i mid-GEN with a new nonce:
  - core_req_o low for exactly one cycle (START), then high with the new counter block;
  - a late core_done_i during START is ignored.
- Async reset asserted in OUT -> pt_valid_o, core_req_o and busy_o go 0 immediately; after release ct_ready_o=0 until cfg_load_i.
